// File: rtl/mult_defs.sv
// mult_defs: shared state encoding and default timeout for the multiplier operand sequencer.
package mult_defs;
  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, HOLD = 2'd3} seqState_t;
  function automatic int defaultTimeout(input int width);
    return 2 * width + 4;
  endfunction
endpackage

// File: rtl/mult_operand_sequencer.sv
// mult_operand_sequencer: feeds operand pairs to a sequential multiplier and collects product, latency and timeout.
module mult_operand_sequencer
  import mult_defs::*;
#(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = defaultTimeout(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_multiplier,
  input  logic [WIDTH-1:0]   in_multiplicand,
  output logic               mult_start,
  output logic [WIDTH-1:0]   mult_multiplier,
  output logic [WIDTH-1:0]   mult_multiplicand,
  input  logic [2*WIDTH-1:0] mult_product,
  input  logic               mult_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [CNT_W-1:0]   out_cycles,
  output logic               out_timeout,
  output logic               busy
);
  seqState_t state;
  logic [CNT_W-1:0] waitCount;
  assign in_ready = (state == IDLE) || (state == HOLD && out_ready);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state             <= IDLE;
      waitCount         <= '0;
      mult_start        <= 1'b0;
      mult_multiplier   <= '0;
      mult_multiplicand <= '0;
      out_valid         <= 1'b0;
      out_product       <= '0;
      out_cycles        <= '0;
      out_timeout       <= 1'b0;
      busy              <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (in_valid) begin
            mult_multiplier   <= in_multiplier;
            mult_multiplicand <= in_multiplicand;
            mult_start        <= 1'b1;
            busy              <= 1'b1;
            state             <= LAUNCH;
          end
        // a done still high from the previous operation is deliberately ignored here
        LAUNCH: begin
          mult_start <= 1'b0;
          waitCount  <= '0;
          state      <= WAIT;
        end
        WAIT:
          if (mult_done) begin
            out_product <= mult_product;
            out_cycles  <= waitCount;
            out_timeout <= 1'b0;
            out_valid   <= 1'b1;
            busy        <= 1'b0;
            state       <= HOLD;
          end else if (waitCount == CNT_W'(TIMEOUT - 1)) begin
            out_product <= '0;
            out_cycles  <= CNT_W'(TIMEOUT);
            out_timeout <= 1'b1;
            out_valid   <= 1'b1;
            busy        <= 1'b0;
            state       <= HOLD;
          end else begin
            waitCount <= waitCount + 1'b1;
          end
        HOLD:
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              mult_multiplier   <= in_multiplier;
              mult_multiplicand <= in_multiplicand;
              mult_start        <= 1'b1;
              busy              <= 1'b1;
              state             <= LAUNCH;
            end else begin
              state <= IDLE;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mult_operand_sequencer.sv
// tb_mult_operand_sequencer: randomized bench with a latency-programmable multiplier stub and a timestamp model.
module tb_mult_operand_sequencer;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam int TO = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_multiplier = '0;
  logic [W-1:0]  in_multiplicand = '0;
  logic          mult_start;
  logic [W-1:0]  mult_multiplier;
  logic [W-1:0]  mult_multiplicand;
  logic [2*W-1:0] mult_product;
  logic          mult_done;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] out_product;
  logic [CW-1:0] out_cycles;
  logic          out_timeout;
  logic          busy;

  always #5 clk = ~clk;

  mult_operand_sequencer #(.WIDTH(W), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_multiplier(in_multiplier), .in_multiplicand(in_multiplicand),
    .mult_start(mult_start), .mult_multiplier(mult_multiplier), .mult_multiplicand(mult_multiplicand),
    .mult_product(mult_product), .mult_done(mult_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_cycles(out_cycles), .out_timeout(out_timeout),
    .busy(busy)
  );

  int passCnt = 0;
  int totalCnt = 0;
  int cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Stub multiplier: latency L means done is first seen in the L-th WAIT cycle; 0 means never.
  int curLat = 1;
  int pendLat = 1;
  int rem = -1;
  logic [2*W-1:0] stubProd;
  assign stubProd = {{W{1'b0}}, mult_multiplier} * {{W{1'b0}}, mult_multiplicand};
  always @(posedge clk or posedge rst)
    if (rst) begin
      mult_done    <= 1'b0;
      mult_product <= '0;
      rem = -1;
    end else begin
      if (in_valid && in_ready) pendLat = curLat;
      if (mult_start) begin
        rem = (pendLat == 0) ? -1 : pendLat - 1;
        mult_done    <= (rem == 0);
        mult_product <= (rem == 0) ? stubProd : (2*W)'($urandom);
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          mult_done    <= 1'b1;
          mult_product <= stubProd;
        end
      end
    end

  // Timestamp model: each accepted pair launches next cycle and holds its result after its wait length.
  bit     hasOp = 0;
  int     launchAt = 0;
  int     resultAt = 0;
  int     expProd = 0;
  int     expCyc = 0;
  int     expTo = 0;
  int     lastA = 0;
  int     lastB = 0;
  bit     mValid, mRdy, mTo;
  always @(posedge clk or posedge rst)
    if (rst) begin
      hasOp = 0;
      lastA = 0;
      lastB = 0;
    end else begin
      mValid = hasOp && cyc >= resultAt;
      mRdy = !hasOp || (mValid && out_ready);
      if (mValid && out_ready) hasOp = 0;
      if (mRdy && in_valid) begin
        mTo = (curLat == 0) || (curLat > TO);
        hasOp = 1;
        launchAt = cyc + 1;
        resultAt = cyc + 2 + (mTo ? TO : curLat);
        expTo = int'(mTo);
        expProd = mTo ? 0 : int'(in_multiplier) * int'(in_multiplicand);
        expCyc = mTo ? TO : curLat - 1;
        lastA = int'(in_multiplier);
        lastB = int'(in_multiplicand);
      end
      cyc++;
    end

  int rProd[$];
  int rCyc[$];
  int rTo[$];
  int startQ[$];
  int hsQ[$];
  bit vNow;
  always @(negedge clk)
    if (!rst) begin
      vNow = hasOp && cyc >= resultAt;
      check("mult_start", mult_start, hasOp && cyc == launchAt);
      check("busy", busy, hasOp && cyc >= launchAt && cyc < resultAt);
      check("out_valid", out_valid, vNow);
      check("in_ready", in_ready, !hasOp || (vNow && out_ready));
      check("mult_multiplier", mult_multiplier, lastA);
      check("mult_multiplicand", mult_multiplicand, lastB);
      if (vNow) begin
        check("out_product", out_product, expProd);
        check("out_cycles", out_cycles, expCyc);
        check("out_timeout", out_timeout, expTo);
      end
      if (mult_start) startQ.push_back(cyc);
      if (out_valid && out_ready) begin
        rProd.push_back(int'(out_product));
        rCyc.push_back(int'(out_cycles));
        rTo.push_back(int'(out_timeout));
        hsQ.push_back(cyc);
      end
    end

  task automatic send(input int a, input int b, input int lat);
    bit ok = 0;
    curLat = lat;
    in_multiplier = W'(a);
    in_multiplicand = W'(b);
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
    end
    check("input_accepted", ok, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitRes(input int n);
    for (int t = 0; t < 200 && rProd.size() < n; t++) @(negedge clk);
    check("result_arrived", rProd.size() >= n, 1);
  endtask

  task automatic checkRes(input int idx, input int p, input int c, input int t);
    if (rProd.size() > idx) begin
      check("lit_product", rProd[idx], p);
      check("lit_cycles", rCyc[idx], c);
      check("lit_timeout", rTo[idx], t);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bit acc;
    repeat (2) @(negedge clk);
    check("rst_mult_start", mult_start, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_product", out_product, 0);
    check("rst_out_cycles", out_cycles, 0);
    check("rst_out_timeout", out_timeout, 0);
    check("rst_mult_multiplier", mult_multiplier, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // single operation
    n = rProd.size();
    send(3, 5, 4);
    waitRes(n + 1);
    checkRes(n, 15, 3, 0);
    // back-to-back with no idle bubble
    @(posedge clk);
    #1 n = rProd.size();
    send(2, 7, 3);
    send(15, 15, 2);
    waitRes(n + 2);
    checkRes(n, 14, 2, 0);
    checkRes(n + 1, 225, 1, 0);
    if (hsQ.size() >= 2 && startQ.size() >= 1) check("b2b_launch", startQ[$], hsQ[hsQ.size()-2] + 1);
    // backpressure
    @(posedge clk);
    #1 out_ready = 1'b0;
    n = rProd.size();
    send(9, 9, 2);
    curLat = 2;
    in_multiplier = 4'd1;
    in_multiplicand = 4'd2;
    in_valid = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_product", out_product, 81);
    check("bp_in_ready", in_ready, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    waitRes(n + 2);
    checkRes(n, 81, 1, 0);
    checkRes(n + 1, 2, 1, 0);
    // timeout, done-wins boundary, late done
    @(posedge clk);
    #1 n = rProd.size();
    send(6, 7, 0);
    waitRes(n + 1);
    checkRes(n, 0, 12, 1);
    @(posedge clk);
    #1 send(5, 3, 12);
    waitRes(n + 2);
    checkRes(n + 1, 15, 11, 0);
    @(posedge clk);
    #1 send(5, 3, 13);
    waitRes(n + 3);
    checkRes(n + 2, 0, 12, 1);
    // stale done left high from the previous operation
    repeat (3) @(posedge clk);
    #1 n = rProd.size();
    check("stale_done_high", mult_done, 1);
    send(2, 3, 3);
    waitRes(n + 1);
    checkRes(n, 6, 2, 0);
    @(posedge clk);
    #1 send(7, 7, 1);
    waitRes(n + 2);
    checkRes(n + 1, 49, 0, 0);
    // reset in the middle of WAIT
    @(posedge clk);
    #1 n = rProd.size();
    send(4, 4, 8);
    repeat (2) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mult_start", mult_start, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 send(4, 4, 3);
    waitRes(n + 1);
    check("no_result_from_aborted", rProd.size(), n + 1);
    checkRes(n, 16, 2, 0);
    // randomized traffic with random backpressure
    @(posedge clk);
    #1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc || !in_valid) begin
        in_valid = $urandom_range(0, 3) != 0;
        in_multiplier = W'($urandom);
        in_multiplicand = W'($urandom);
        curLat = $urandom_range(0, 14);
      end
      out_ready = $urandom_range(0, 3) != 0;
    end
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
